pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Supervises NUM_PLL PLL instances from the free-running reference clock domain.
//  Per channel: pulses the PLL reset, waits for lock with a timeout, debounces lock, then releases that
//  channel's domain reset. On lock loss it re-asserts the domain reset and retries, up to MAX_RETRY times.
//  Sits between the PLL wrappers and the per-clock-domain reset trees; all_locked feeds the platform status CSR.
// PARAMETERS
//  NUM_PLL          4       number of supervised PLL channels (1..16)
//  PLL_RST_CYC      16      refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT_CYC 100000  max cycles in WAIT_LOCK before the attempt counts as failed (>=1)
//  LOCK_STABLE_CYC  1024    consecutive synced-locked cycles required before RUN (>=1)
//  MAX_RETRY        3       failed attempts tolerated before FAULT (0 = first failure faults)
// PORTS
//  refclk        in   1        free-running reference clock; the only clock
//  rst_n         in   1        asynchronous active-low reset
//  pll_locked    in   NUM_PLL  raw PLL lock outputs, asynchronous to refclk
//  force_relock  in   NUM_PLL  per-channel single-cycle request to restart that channel
//  fault_clr     in   1        single-cycle pulse: clears every FAULT channel and its retry count
//  pll_rst       out  NUM_PLL  active-high reset to each PLL
//  domain_rst_n  out  NUM_PLL  active-low reset to each downstream clock domain
//  all_locked    out  1        high when every channel is in RUN
//  fault         out  NUM_PLL  channel is in FAULT
//  retry_cnt     out  4*NUM_PLL  per-channel failed-attempt count, saturating at 15
// BEHAVIOUR
//  Reset (rst_n low, asynchronous):
//   - Every channel goes to PLL_RST with counters cleared.
//   - Outputs: pll_rst = all 1, domain_rst_n = 0, all_locked = 0, fault = 0, retry_cnt = 0.
//  Synchronisation: pll_locked passes through a 2-flop synchroniser per bit (lk_s). All decisions use lk_s,
//   so a raw edge acts 2 cycles later.
//  Per-channel FSM, one shared cycle counter per channel, sized $clog2 of the largest limit:
//   - PLL_RST: pll_rst=1. After PLL_RST_CYC cycles -> WAIT_LOCK, counter=0.
//   - WAIT_LOCK: pll_rst=0.
//       lk_s=1 -> STABLE, counter=0.
//       Counter reaches LOCK_TIMEOUT_CYC-1 with lk_s=0 -> FAIL.
//   - STABLE: lk_s=0 -> WAIT_LOCK, timeout counter restarts; this is not a failure.
//       LOCK_STABLE_CYC consecutive lk_s=1 cycles -> RUN.
//   - RUN: domain_rst_n=1. lk_s=0 -> FAIL.
//       domain_rst_n drops registered on the same edge the FSM leaves RUN.
//   - FAIL (1 cycle): retry_cnt+=1 (saturating).
//       If the failures now exceed MAX_RETRY -> FAULT, else -> PLL_RST.
//   - FAULT: pll_rst=1, domain_rst_n=0, fault=1. Stays until fault_clr -> PLL_RST with retry_cnt=0.
//  force_relock[i] in any state except FAULT:
//   - -> PLL_RST next cycle, domain_rst_n[i]=0 next cycle; retry_cnt unchanged.
//   - Ignored in FAULT.
//  Priority when events coincide: rst_n > fault_clr > force_relock > lock loss/timeout.
//  Success never clears retry_cnt; only rst_n or fault_clr do. retry_cnt is diagnostic only.
//  domain_rst_n is 0 in every state except RUN.
//  all_locked is registered: high the cycle after the last channel enters RUN, low the cycle after any channel leaves.
//  Channels are independent. Adding or removing a channel never resets another channel.
//  Latency:
//   - rst_n deassert to first domain_rst_n rise is at least
//     PLL_RST_CYC + 2 (sync) + LOCK_STABLE_CYC + 1 cycles, with lock already high.
//   - Raw lock loss to domain_rst_n fall is 3 cycles.
//  A glitch on pll_locked shorter than 1 refclk cycle may or may not be sampled; if sampled in RUN it causes a retry.
// TESTING (NUM_PLL=2, PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRY=1)
//  1. Release rst_n with pll_locked=2'b11 held
//     -> pll_rst falls at cycle 4; domain_rst_n=2'b11 at cycle 4+2+8+1=15;
//        all_locked high at cycle 16; fault=0.
//  2. Channel 0 locked, lock toggles every 5 cycles during STABLE
//     -> domain_rst_n[0] never rises; retry_cnt[0] stays 0.
//  3. pll_locked[1] held 0
//     -> timeout after 20 cycles, retry_cnt[1]=1, pll_rst[1] pulses again;
//        after the second timeout fault[1]=1, pll_rst[1]=1.
//        fault_clr -> retry_cnt[1]=0 and a new PLL_RST.
//  4. In RUN, drop pll_locked[0]
//     -> domain_rst_n[0]=0 within 3 cycles, all_locked=0 the next cycle;
//        channel 1 unaffected; retry_cnt[0]=1.
//  5. force_relock[1] in RUN and fault_clr asserted in the same cycle with channel 0 in FAULT
//     -> both channels go to PLL_RST; retry_cnt[1] unchanged; retry_cnt[0]=0.
//  6. Assert rst_n low in the middle of STABLE
//     -> all outputs take their reset values asynchronously, with no refclk edge needed.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// pll_lock_supervisor: per-channel PLL reset / lock-wait / debounce / retry sequencing on refclk.
// Each channel owns its FSM, cycle counter, retry count and lock synchroniser; channels never interact.
module pll_lock_supervisor #(
  parameter int NUM_PLL          = 4,
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_TIMEOUT_CYC = 100000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 3
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic [NUM_PLL-1:0]   pll_locked,
  input  logic [NUM_PLL-1:0]   force_relock,
  input  logic                 fault_clr,
  output logic [NUM_PLL-1:0]   pll_rst,
  output logic [NUM_PLL-1:0]   domain_rst_n,
  output logic                 all_locked,
  output logic [NUM_PLL-1:0]   fault,
  output logic [4*NUM_PLL-1:0] retry_cnt
);

  localparam int LIM_A   = (PLL_RST_CYC > LOCK_STABLE_CYC) ? PLL_RST_CYC : LOCK_STABLE_CYC;
  localparam int LIM_MAX = (LIM_A > LOCK_TIMEOUT_CYC) ? LIM_A : LOCK_TIMEOUT_CYC;
  localparam int CW      = (LIM_MAX > 1) ? $clog2(LIM_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL,
    S_FAULT
  } state_e;

  logic r_all_locked;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) r_all_locked <= 1'b0;
    else        r_all_locked <= &domain_rst_n;
  end

  assign all_locked = r_all_locked;

  for (genvar i = 0; i < NUM_PLL; i++) begin : g_ch
    state_e          r_state, w_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [3:0]      r_retry, w_retry_next, w_retry_inc;
    logic            r_sync1, r_lk_s;
    logic            r_pll_rst, r_dom_rst_n, r_fault;

    // Lock reported by a PLL held in reset is meaningless, so the synchroniser restarts with each attempt.
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b0;
        r_lk_s  <= 1'b0;
      end else if (r_pll_rst) begin
        r_sync1 <= 1'b0;
        r_lk_s  <= 1'b0;
      end else begin
        r_sync1 <= pll_locked[i];
        r_lk_s  <= r_sync1;
      end
    end

    assign w_retry_inc = (r_retry == 4'hF) ? 4'hF : r_retry + 4'd1;

    // NOTE: every variable gets its default first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
      w_next       = r_state;
      w_cnt_next   = r_cnt;
      w_retry_next = r_retry;
      case (r_state)
        S_PLL_RST: begin
          if (r_cnt == RST_LAST) begin
            w_next     = S_WAIT_LOCK;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lk_s) begin
            w_next     = S_STABLE;
            w_cnt_next = '0;
          end else if (r_cnt == TMO_LAST) begin
            w_next     = S_FAIL;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!r_lk_s) begin
            w_next     = S_WAIT_LOCK;
            w_cnt_next = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_next     = S_RUN;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
        S_RUN: begin
          if (!r_lk_s) w_next = S_FAIL;
        end
        S_FAIL: begin
          w_retry_next = w_retry_inc;
          w_cnt_next   = '0;
          w_next       = (int'(w_retry_inc) > MAX_RETRY) ? S_FAULT : S_PLL_RST;
        end
        S_FAULT: begin
          w_next = S_FAULT;
        end
        default: begin
          w_next     = S_PLL_RST;
          w_cnt_next = '0;
        end
      endcase

      // fault_clr only acts in FAULT and force_relock is ignored there, so the two never contend.
      if (r_state == S_FAULT) begin
        if (fault_clr) begin
          w_next       = S_PLL_RST;
          w_cnt_next   = '0;
          w_retry_next = '0;
        end
      end else if (force_relock[i]) begin
        w_next     = S_PLL_RST;
        w_cnt_next = '0;
      end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        r_state     <= S_PLL_RST;
        r_cnt       <= '0;
        r_retry     <= '0;
        r_pll_rst   <= 1'b1;
        r_dom_rst_n <= 1'b0;
        r_fault     <= 1'b0;
      end else begin
        r_state     <= w_next;
        r_cnt       <= w_cnt_next;
        r_retry     <= w_retry_next;
        r_pll_rst   <= (w_next == S_PLL_RST) || (w_next == S_FAULT);
        r_dom_rst_n <= (w_next == S_RUN);
        r_fault     <= (w_next == S_FAULT);
      end
    end

    assign pll_rst[i]          = r_pll_rst;
    assign domain_rst_n[i]     = r_dom_rst_n;
    assign fault[i]            = r_fault;
    assign retry_cnt[4*i +: 4] = r_retry;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
// tb_pll_lock_supervisor: scoreboard bench; stimulus pushes cycle-stamped expectations, a negedge monitor pops them.
module tb_pll_lock_supervisor;

  localparam int NUM_PLL = 2;

  logic                 refclk;
  logic                 rst_n;
  logic [NUM_PLL-1:0]   pll_locked;
  logic [NUM_PLL-1:0]   force_relock;
  logic                 fault_clr;
  logic [NUM_PLL-1:0]   pll_rst;
  logic [NUM_PLL-1:0]   domain_rst_n;
  logic                 all_locked;
  logic [NUM_PLL-1:0]   fault;
  logic [4*NUM_PLL-1:0] retry_cnt;

  pll_lock_supervisor #(
    .NUM_PLL          (NUM_PLL),
    .PLL_RST_CYC      (4),
    .LOCK_TIMEOUT_CYC (20),
    .LOCK_STABLE_CYC  (8),
    .MAX_RETRY        (1)
  ) u_dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .fault_clr    (fault_clr),
    .pll_rst      (pll_rst),
    .domain_rst_n (domain_rst_n),
    .all_locked   (all_locked),
    .fault        (fault),
    .retry_cnt    (retry_cnt)
  );

  typedef enum {F_PLL, F_DOM, F_ALL, F_FAULT, F_RETRY} field_e;

  typedef struct {
    string       tag;
    int unsigned cyc;
    field_e      fld;
    logic [7:0]  val;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic exp_at(input string tag, input int unsigned at, input field_e f, input logic [7:0] v);
    exp_t e;
    e.tag = $sformatf("%s@%0d", tag, at);
    e.cyc = at;
    e.fld = f;
    e.val = v;
    q.push_back(e);
  endtask

  function automatic logic [7:0] get_obs(input field_e f);
    case (f)
      F_PLL:   return {6'd0, pll_rst};
      F_DOM:   return {6'd0, domain_rst_n};
      F_ALL:   return {7'd0, all_locked};
      F_FAULT: return {6'd0, fault};
      F_RETRY: return retry_cnt;
      default: return 8'h00;
    endcase
  endfunction

  task automatic exp_reset_vals(input string tag, input int unsigned at);
    exp_at({tag, "_pll_rst"}, at, F_PLL,   8'h03);
    exp_at({tag, "_dom"},     at, F_DOM,   8'h00);
    exp_at({tag, "_all"},     at, F_ALL,   8'h00);
    exp_at({tag, "_fault"},   at, F_FAULT, 8'h00);
    exp_at({tag, "_retry"},   at, F_RETRY, 8'h00);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Monitor: one ns after each falling edge, compare every expectation stamped with the current cycle.
  initial begin
    forever begin
      @(negedge refclk);
      #1;
      begin
        int k;
        k = 0;
        while (k < q.size()) begin
          if (q[k].cyc == cyc) begin
            check(q[k].tag, get_obs(q[k].fld), q[k].val);
            q.delete(k);
          end else begin
            k++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r, n, m, p, s;
    rst_n        = 1'b0;
    pll_locked   = 2'b11;
    force_relock = 2'b00;
    fault_clr    = 1'b0;

    tick(2);
    exp_reset_vals("rst", cyc);

    // 1: release reset with both locks already high
    tick(1);
    r = cyc;
    rst_n = 1'b1;
    exp_at("t1_pll_rst_hi", r + 3,  F_PLL,   8'h03);
    exp_at("t1_pll_rst_lo", r + 4,  F_PLL,   8'h00);
    exp_at("t1_dom_lo",     r + 14, F_DOM,   8'h00);
    exp_at("t1_dom_hi",     r + 15, F_DOM,   8'h03);
    exp_at("t1_all_lo",     r + 15, F_ALL,   8'h00);
    exp_at("t1_all_hi",     r + 16, F_ALL,   8'h01);
    exp_at("t1_fault",      r + 16, F_FAULT, 8'h00);
    exp_at("t1_retry",      r + 16, F_RETRY, 8'h00);
    tick(20);

    // 2: restart channel 0 and toggle its lock every 5 cycles: debounce must never complete
    n = cyc;
    force_relock = 2'b01;
    pll_locked[0] = 1'b0;
    exp_at("t2_dom_force", n + 1, F_DOM, 8'h02);
    exp_at("t2_pll_force", n + 1, F_PLL, 8'h01);
    exp_at("t2_all_drop",  n + 2, F_ALL, 8'h00);
    tick(1);
    force_relock = 2'b00;
    for (int k = 0; k < 60; k++) begin
      pll_locked[0] = ((k / 5) % 2) == 0;
      exp_at("t2_dom_toggle", cyc, F_DOM, 8'h02);
      tick(1);
    end
    exp_at("t2_retry", cyc, F_RETRY, 8'h00);
    pll_locked[0] = 1'b1;
    exp_at("t2_dom_relock", cyc + 20, F_DOM, 8'h03);
    exp_at("t2_all_relock", cyc + 21, F_ALL, 8'h01);
    tick(22);

    // 3: channel 1 never locks: two timeouts, FAULT, then fault_clr
    m = cyc;
    force_relock = 2'b10;
    pll_locked[1] = 1'b0;
    exp_at("t3_dom_force",  m + 1,  F_DOM,   8'h01);
    exp_at("t3_pll_hi",     m + 4,  F_PLL,   8'h02);
    exp_at("t3_pll_lo",     m + 5,  F_PLL,   8'h00);
    exp_at("t3_pll_fail",   m + 25, F_PLL,   8'h00);
    exp_at("t3_retry0",     m + 25, F_RETRY, 8'h00);
    exp_at("t3_pll_retry",  m + 26, F_PLL,   8'h02);
    exp_at("t3_retry1",     m + 26, F_RETRY, 8'h10);
    exp_at("t3_fault_pre",  m + 50, F_FAULT, 8'h00);
    exp_at("t3_fault",      m + 51, F_FAULT, 8'h02);
    exp_at("t3_pll_fault",  m + 51, F_PLL,   8'h02);
    exp_at("t3_retry2",     m + 51, F_RETRY, 8'h20);
    exp_at("t3_dom_ch0",    m + 51, F_DOM,   8'h01);
    exp_at("t3_fault_hold", m + 60, F_FAULT, 8'h02);
    tick(1);
    force_relock = 2'b00;
    tick(59);
    p = cyc;
    fault_clr = 1'b1;
    pll_locked[1] = 1'b1;
    exp_at("t3_clr_fault",  p + 1,  F_FAULT, 8'h00);
    exp_at("t3_clr_retry",  p + 1,  F_RETRY, 8'h00);
    exp_at("t3_clr_pll",    p + 1,  F_PLL,   8'h02);
    exp_at("t3_clr_pll_hi", p + 4,  F_PLL,   8'h02);
    exp_at("t3_clr_pll_lo", p + 5,  F_PLL,   8'h00);
    exp_at("t3_clr_dom_lo", p + 15, F_DOM,   8'h01);
    exp_at("t3_clr_dom_hi", p + 16, F_DOM,   8'h03);
    exp_at("t3_clr_all",    p + 17, F_ALL,   8'h01);
    tick(1);
    fault_clr = 1'b0;
    tick(19);

    // 4: lock loss on channel 0 in RUN, then it stays unlocked until FAULT
    n = cyc;
    pll_locked[0] = 1'b0;
    exp_at("t4_dom_hold",    n + 2,  F_DOM,   8'h03);
    exp_at("t4_dom_drop",    n + 3,  F_DOM,   8'h02);
    exp_at("t4_all_hold",    n + 3,  F_ALL,   8'h01);
    exp_at("t4_all_drop",    n + 4,  F_ALL,   8'h00);
    exp_at("t4_dom_ch1",     n + 4,  F_DOM,   8'h02);
    exp_at("t4_retry",       n + 4,  F_RETRY, 8'h01);
    exp_at("t4_pll",         n + 4,  F_PLL,   8'h01);
    exp_at("t4_fault_pre",   n + 28, F_FAULT, 8'h00);
    exp_at("t4_fault",       n + 29, F_FAULT, 8'h01);
    exp_at("t4_fault_retry", n + 29, F_RETRY, 8'h02);
    exp_at("t4_fault_pll",   n + 29, F_PLL,   8'h01);
    tick(30);
    // brief lock loss on channel 1 so its retry count is non-zero going into the next step
    pll_locked[1] = 1'b0;
    exp_at("t4b_dom_hold",  n + 32, F_DOM,   8'h02);
    exp_at("t4b_dom_drop",  n + 33, F_DOM,   8'h00);
    exp_at("t4b_retry",     n + 34, F_RETRY, 8'h12);
    exp_at("t4b_dom_run",   n + 49, F_DOM,   8'h02);
    exp_at("t4b_retry_run", n + 49, F_RETRY, 8'h12);
    tick(3);
    pll_locked[1] = 1'b1;
    tick(22);

    // 5: force_relock[1] in RUN together with fault_clr while channel 0 is in FAULT
    s = cyc;
    force_relock = 2'b10;
    fault_clr = 1'b1;
    pll_locked[0] = 1'b1;
    exp_at("t5_fault_pre", s,     F_FAULT, 8'h01);
    exp_at("t5_dom_pre",   s,     F_DOM,   8'h02);
    exp_at("t5_pll",       s + 1, F_PLL,   8'h03);
    exp_at("t5_dom",       s + 1, F_DOM,   8'h00);
    exp_at("t5_fault",     s + 1, F_FAULT, 8'h00);
    exp_at("t5_retry",     s + 1, F_RETRY, 8'h10);
    tick(1);
    force_relock = 2'b00;
    fault_clr = 1'b0;

    // 6: asynchronous reset in the middle of STABLE, checked before any further refclk edge
    tick(10);
    exp_at("t6_pll_pre", cyc, F_PLL, 8'h00);
    exp_at("t6_dom_pre", cyc, F_DOM, 8'h00);
    tick(1);
    rst_n = 1'b0;
    exp_reset_vals("t6_async", cyc);
    tick(2);
    rst_n = 1'b1;

    for (int k = 0; k < 100 && q.size() != 0; k++) tick(1);
    #2;
    check("drain_pending", 8'(q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
